keypad_entry_ctrl: RTL and testbench

Sequencer between the keypad decoder and the seven-segment display for Numberle guess entry. Collects up to four decimal digits from single-cycle keypad presses, handles backspace and submit buttons, presents the finished guess to game logic over a valid/ready handshake, and time-multiplexes the entered digits onto the four-digit display.

---
 rtl/keypad_entry_ctrl.sv | 124 ++++++++++++
 tb/tb_keypad_entry_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - Numberle guess entry sequencer and 4-digit display multiplexer
// Collects four digits, handles backspace/submit, hands the guess off over valid/ready.
module keypad_entry_ctrl #(
   parameter int REFRESH_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [3:0]  key_code,
   input  logic        key_valid,
   input  logic        btn_del,
   input  logic        btn_sub,
   input  logic        guess_ready,
   output logic [15:0] guess,
   output logic        guess_valid,
   output logic [2:0]  count,
   output logic [3:0]  an,
   output logic [3:0]  hex_out
);

   localparam int CW = $clog2(REFRESH_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   typedef enum logic [1:0] {
      ENTRY  = 2'd0,
      FULL   = 2'd1,
      SUBMIT = 2'd2
   } state_t;

   state_t        state, state_nxt;
   logic [15:0]   guess_nxt;
   logic [2:0]    count_nxt;
   logic          btn_del_q, btn_sub_q;
   logic          del_ev, sub_ev;
   logic [1:0]    wr_idx, bs_idx;
   logic [CW-1:0] refresh_cnt, refresh_nxt;
   logic [1:0]    slot, slot_nxt;
   logic          show;
   logic [3:0]    an_nxt, hex_nxt;

   assign del_ev = btn_del & ~btn_del_q;
   assign sub_ev = btn_sub & ~btn_sub_q;
   assign wr_idx = count[1:0];
   assign bs_idx = count[1:0] - 2'd1;

   // Digit i lives at guess[15-4i -: 4]; 15-4i is {~i, 2'b11} for a 2-bit i.
   always_comb begin
      state_nxt = state;
      guess_nxt = guess;
      count_nxt = count;
      case (state)
         ENTRY: begin
            if (del_ev && count != 3'd0) begin
               guess_nxt[{~bs_idx, 2'b11} -: 4] = 4'd0;
               count_nxt = count - 3'd1;
            end else if (key_valid && key_code <= 4'd9) begin
               guess_nxt[{~wr_idx, 2'b11} -: 4] = key_code;
               count_nxt = count + 3'd1;
               if (count == 3'd3) state_nxt = FULL;
            end
         end
         FULL: begin
            if (sub_ev) begin
               state_nxt = SUBMIT;
            end else if (del_ev) begin
               guess_nxt[3:0] = 4'd0;
               count_nxt = 3'd3;
               state_nxt = ENTRY;
            end
         end
         SUBMIT: begin
            if (guess_valid && guess_ready) begin
               guess_nxt = 16'd0;
               count_nxt = 3'd0;
               state_nxt = ENTRY;
            end
         end
         default: state_nxt = ENTRY;
      endcase
   end

   // Display registers are fed from next-state values so the shown digit never lags the guess.
   always_comb begin
      refresh_nxt = refresh_cnt + CW'(1);
      slot_nxt    = slot;
      if (refresh_cnt == CNT_MAX) begin
         refresh_nxt = '0;
         slot_nxt    = slot + 2'd1;
      end
      show    = (state_nxt == SUBMIT) || ({1'b0, slot_nxt} < count_nxt);
      an_nxt  = 4'b1111;
      hex_nxt = 4'd0;
      if (show) begin
         an_nxt  = ~(4'b1000 >> slot_nxt);
         hex_nxt = guess_nxt[{~slot_nxt, 2'b11} -: 4];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ENTRY;
         guess       <= 16'd0;
         count       <= 3'd0;
         guess_valid <= 1'b0;
         btn_del_q   <= 1'b0;
         btn_sub_q   <= 1'b0;
         refresh_cnt <= '0;
         slot        <= 2'd0;
         an          <= 4'b1111;
         hex_out     <= 4'd0;
      end else begin
         state       <= state_nxt;
         guess       <= guess_nxt;
         count       <= count_nxt;
         guess_valid <= (state_nxt == SUBMIT);
         btn_del_q   <= btn_del;
         btn_sub_q   <= btn_sub;
         refresh_cnt <= refresh_nxt;
         slot        <= slot_nxt;
         an          <= an_nxt;
         hex_out     <= hex_nxt;
      end
   end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - directed-vector bench for keypad_entry_ctrl
module tb_keypad_entry_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  key_code = 4'd0;
   logic        key_valid = 1'b0;
   logic        btn_del = 1'b0;
   logic        btn_sub = 1'b0;
   logic        guess_ready = 1'b0;
   logic [15:0] guess;
   logic        guess_valid;
   logic [2:0]  count;
   logic [3:0]  an;
   logic [3:0]  hex_out;

   int n_vec  = 0;
   int n_miss = 0;

   keypad_entry_ctrl #(.REFRESH_DIV(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .btn_del     (btn_del),
      .btn_sub     (btn_sub),
      .guess_ready (guess_ready),
      .guess       (guess),
      .guess_valid (guess_valid),
      .count       (count),
      .an          (an),
      .hex_out     (hex_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic key(input logic [3:0] c);
      key_code  = c;
      key_valid = 1'b1;
      step();
      key_valid = 1'b0;
   endtask

   task automatic del_press();
      btn_del = 1'b1;
      step();
      btn_del = 1'b0;
      step();
   endtask

   task automatic sub_press();
      btn_sub = 1'b1;
      step();
      btn_sub = 1'b0;
      step();
   endtask

   initial begin
      // reset state
      step();
      chk("rst_guess", guess, 16'h0000);
      chk("rst_count", 16'(count), 16'd0);
      chk("rst_valid", 16'(guess_valid), 16'd0);
      chk("rst_an", 16'(an), 16'hF);
      chk("rst_hex", 16'(hex_out), 16'h0);
      rst_n = 1'b1;
      step();

      // entry, non-digit rejected
      key(4'hA);
      chk("key_a_count", 16'(count), 16'd0);
      key(4'd3); chk("cnt1", 16'(count), 16'd1);
      key(4'd7); chk("cnt2", 16'(count), 16'd2);
      key(4'd0); chk("cnt3", 16'(count), 16'd3);
      key(4'd9); chk("cnt4", 16'(count), 16'd4);
      chk("guess_3709", guess, 16'h3709);

      // overflow and backspace
      key(4'd5);
      chk("ovf_guess", guess, 16'h3709);
      chk("ovf_count", 16'(count), 16'd4);
      del_press();
      chk("bs_guess", guess, 16'h3700);
      chk("bs_count", 16'(count), 16'd3);
      key(4'd1);
      chk("refill_guess", guess, 16'h3701);

      // submit handshake
      for (int i = 0; i < 4; i++) del_press();
      chk("cleared_count", 16'(count), 16'd0);
      chk("cleared_guess", guess, 16'h0000);
      key(4'd1); key(4'd2); key(4'd3); key(4'd4);
      btn_sub = 1'b1;
      step();
      btn_sub = 1'b0;
      chk("sub_valid", 16'(guess_valid), 16'd1);
      for (int i = 0; i < 10; i++) begin
         key_code = 4'd6; key_valid = 1'b1;
         btn_del = i[0]; btn_sub = ~i[0];
         step();
      end
      key_valid = 1'b0; btn_del = 1'b0; btn_sub = 1'b0;
      step();
      chk("frozen_guess", guess, 16'h1234);
      chk("frozen_count", 16'(count), 16'd4);
      chk("frozen_valid", 16'(guess_valid), 16'd1);
      guess_ready = 1'b1;
      step();
      guess_ready = 1'b0;
      chk("hs_valid", 16'(guess_valid), 16'd0);
      chk("hs_count", 16'(count), 16'd0);
      chk("hs_guess", guess, 16'h0000);

      // simultaneous events: sub beats del and key at count 4
      key(4'd5); key(4'd6); key(4'd7); key(4'd8);
      btn_sub = 1'b1; btn_del = 1'b1; key_code = 4'd2; key_valid = 1'b1;
      step();
      btn_sub = 1'b0; btn_del = 1'b0; key_valid = 1'b0;
      chk("sim_valid", 16'(guess_valid), 16'd1);
      chk("sim_guess", guess, 16'h5678);
      guess_ready = 1'b1;
      step();
      guess_ready = 1'b0;
      // del beats key at count 2
      key(4'd4); key(4'd5);
      btn_del = 1'b1; key_code = 4'd8; key_valid = 1'b1;
      step();
      btn_del = 1'b0; key_valid = 1'b0;
      chk("delkey_count", 16'(count), 16'd1);
      chk("delkey_guess", guess, 16'h4000);
      step();

      // held buttons
      key(4'd1); key(4'd2);
      chk("held_pre", 16'(count), 16'd3);
      btn_del = 1'b1;
      for (int i = 0; i < 50; i++) step();
      btn_del = 1'b0;
      step();
      chk("held_del_count", 16'(count), 16'd2);
      chk("held_del_guess", guess, 16'h4100);
      btn_sub = 1'b1;
      for (int i = 0; i < 10; i++) step();
      btn_sub = 1'b0;
      step();
      chk("held_sub_valid", 16'(guess_valid), 16'd0);
      chk("held_sub_count", 16'(count), 16'd2);

      // display scan with 0x12 at count 2
      del_press(); del_press();
      key(4'd1); key(4'd2);
      chk("disp_guess", guess, 16'h1200);
      for (int i = 0; i < 40 && an !== 4'b1011; i++) step();
      chk("disp_sync1", 16'(an), 16'hB);
      for (int i = 0; i < 40 && an !== 4'b0111; i++) step();
      chk("disp_s0_an", 16'(an), 16'h7);
      chk("disp_s0_hex", 16'(hex_out), 16'h1);
      repeat (3) step();
      chk("disp_s0_end", 16'(an), 16'h7);
      step();
      chk("disp_s1_an", 16'(an), 16'hB);
      chk("disp_s1_hex", 16'(hex_out), 16'h2);
      repeat (4) step();
      chk("disp_s2_an", 16'(an), 16'hF);
      chk("disp_s2_hex", 16'(hex_out), 16'h0);
      repeat (4) step();
      chk("disp_s3_an", 16'(an), 16'hF);
      chk("disp_s3_hex", 16'(hex_out), 16'h0);
      repeat (4) step();
      chk("disp_wrap_an", 16'(an), 16'h7);
      chk("disp_wrap_hex", 16'(hex_out), 16'h1);

      // reset in the middle of SUBMIT
      key(4'd3); key(4'd4);
      sub_press();
      chk("pre_rst_valid", 16'(guess_valid), 16'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 16'(guess_valid), 16'd0);
      chk("arst_guess", guess, 16'h0000);
      chk("arst_count", 16'(count), 16'd0);
      chk("arst_an", 16'(an), 16'hF);
      chk("arst_hex", 16'(hex_out), 16'h0);
      step();
      rst_n = 1'b1;
      guess_ready = 1'b1;
      step();
      guess_ready = 1'b0;
      chk("post_rst_valid", 16'(guess_valid), 16'd0);
      chk("post_rst_an", 16'(an), 16'hF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
